// File: rtl/acceso_parqueo_ctrl_param_if.sv
// Lane/keypad/actuator bundle for the parking access controller.
// master: lane side (drives sensors+PIN), slave: controller.
interface acceso_parqueo_ctrl_param_if #(
  parameter int unsigned PIN_WIDTH = 16,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned OCC_W     = 4
);
  logic                 sensor_llegada_vehiculo;
  logic                 sensor_ingreso_vehiculo;
  logic                 sensor_salida_vehiculo;
  logic [PIN_WIDTH-1:0] clave_ingresada;
  logic                 clave_valida;
  logic                 senal_compuerta;
  logic                 senal_alarma_pin;
  logic                 senal_alarma_bloqueo;
  logic                 senal_lleno;
  logic                 senal_timeout;
  logic [CNT_W-1:0]     cuenta_intentos;
  logic [OCC_W-1:0]     ocupacion;

  modport master (
    output sensor_llegada_vehiculo,
    output sensor_ingreso_vehiculo,
    output sensor_salida_vehiculo,
    output clave_ingresada,
    output clave_valida,
    input  senal_compuerta,
    input  senal_alarma_pin,
    input  senal_alarma_bloqueo,
    input  senal_lleno,
    input  senal_timeout,
    input  cuenta_intentos,
    input  ocupacion
  );

  modport slave (
    input  sensor_llegada_vehiculo,
    input  sensor_ingreso_vehiculo,
    input  sensor_salida_vehiculo,
    input  clave_ingresada,
    input  clave_valida,
    output senal_compuerta,
    output senal_alarma_pin,
    output senal_alarma_bloqueo,
    output senal_lleno,
    output senal_timeout,
    output cuenta_intentos,
    output ocupacion
  );
endinterface

// File: rtl/acceso_parqueo_ctrl_param.sv
// Parking gate controller: PIN check with attempt limit, intrusion
// block alarm, occupancy counter with full flag, optional gate timeout.
// Ports: clock, reset (sync, active-high), bus (slave modport) carrying
//   sensors, clave_ingresada/clave_valida in; gate, alarms, lleno,
//   timeout pulse, cuenta_intentos, ocupacion out (all registered).
// Optional: define ACCESO_TIMEOUT_EN to close an unused open gate after
//   TIMEOUT_CICLOS cycles (senal_timeout pulses); otherwise tied 0.
module acceso_parqueo_ctrl_param #(
  parameter int unsigned          PIN_WIDTH      = 16,
  parameter logic [PIN_WIDTH-1:0] PIN_CORRECTO   = 16'h3257,
  parameter int unsigned          MAX_INTENTOS   = 3,
  parameter int unsigned          CAPACIDAD      = 8,
  parameter int unsigned          OCC_W          = 4,
  parameter int unsigned          TIMEOUT_CICLOS = 64,
  localparam int unsigned         CNT_W = $clog2(MAX_INTENTOS + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  acceso_parqueo_ctrl_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESPERA_PIN,
    S_ALARMA_PIN,
    S_ABIERTA,
    S_BLOQUEO
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OCC_W-1:0]   r_occ;
  logic [OCC_W-1:0]   w_occ_nxt;
  logic               r_gate;
  logic               r_alpin;
  logic               w_alpin_nxt;
  logic               r_blk;
  logic               r_lleno;
  logic               r_to;
  logic               w_to;
  logic               r_ing_q;
  logic               r_sal_q;
  logic               w_ll;
  logic               w_ing;
  logic               w_ok;
  logic               w_bad;
  logic               w_ing_fall;
  logic               w_sal_rise;
  logic               w_inc;

  assign w_ll       = bus.sensor_llegada_vehiculo;
  assign w_ing      = bus.sensor_ingreso_vehiculo;
  assign w_ok       = bus.clave_valida &&
                      (bus.clave_ingresada == PIN_CORRECTO);
  assign w_bad      = bus.clave_valida && !w_ok;
  assign w_ing_fall = r_ing_q && !w_ing;
  assign w_sal_rise = bus.sensor_salida_vehiculo && !r_sal_q;

`ifdef ACCESO_TIMEOUT_EN
  localparam int unsigned TMR_W =
    (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT_CICLOS - 1);

  logic [TMR_W-1:0] r_tmr;
  logic             r_visto;
  logic             w_tmo_hit;

  // Counting stops for good once a vehicle has been seen in the gate.
  assign w_tmo_hit = !r_visto && !w_ing && (r_tmr == TMR_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CICLOS != 0);
`endif

  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_alpin_nxt = r_alpin;
    w_inc       = 1'b0;
    w_to        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_ing)
          w_nxt = S_BLOQUEO;
        else if (w_ll && !r_lleno)
          w_nxt = S_ESPERA_PIN;
      end
      S_ESPERA_PIN: begin
        if (w_ing) begin
          w_nxt = S_BLOQUEO;
        end else if (w_ok) begin
          w_nxt     = S_ABIERTA;
          w_cnt_nxt = '0;
        end else if (w_bad) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MAX_INTENTOS - 1)) begin
            w_nxt       = S_ALARMA_PIN;
            w_alpin_nxt = 1'b1;
          end
        end else if (!w_ll) begin
          w_nxt     = S_IDLE;
          w_cnt_nxt = '0;
        end
      end
      S_ALARMA_PIN: begin
        if (w_ing) begin
          w_nxt = S_BLOQUEO;
        end else if (w_ok) begin
          w_nxt       = S_ABIERTA;
          w_alpin_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_ABIERTA: begin
        if (w_ing_fall) begin
          w_nxt = S_IDLE;
          w_inc = 1'b1;
        end
`ifdef ACCESO_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_nxt = S_IDLE;
          w_to  = 1'b1;
        end
`endif
      end
      S_BLOQUEO: begin
        // A pin alarm carried in here stays up until a good PIN.
        if (w_ok) begin
          w_nxt       = S_ABIERTA;
          w_alpin_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_inc && w_sal_rise)
      w_occ_nxt = r_occ;
    else if (w_inc && (r_occ != OCC_W'(CAPACIDAD)))
      w_occ_nxt = r_occ + 1'b1;
    else if (w_sal_rise && (r_occ != '0))
      w_occ_nxt = r_occ - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_occ   <= '0;
      r_gate  <= 1'b0;
      r_alpin <= 1'b0;
      r_blk   <= 1'b0;
      r_lleno <= 1'b0;
      r_to    <= 1'b0;
      r_ing_q <= 1'b0;
      r_sal_q <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_occ   <= w_occ_nxt;
      r_gate  <= (w_nxt == S_ABIERTA);
      r_alpin <= w_alpin_nxt;
      r_blk   <= (w_nxt == S_BLOQUEO);
      r_lleno <= (w_occ_nxt == OCC_W'(CAPACIDAD));
      r_to    <= w_to;
      r_ing_q <= w_ing;
      r_sal_q <= bus.sensor_salida_vehiculo;
    end
  end

`ifdef ACCESO_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmr   <= '0;
      r_visto <= 1'b0;
    end else if (w_nxt == S_ABIERTA && r_state != S_ABIERTA) begin
      r_tmr   <= '0;
      r_visto <= 1'b0;
    end else if (r_state == S_ABIERTA) begin
      if (w_ing)
        r_visto <= 1'b1;
      else if (!r_visto)
        r_tmr <= r_tmr + 1'b1;
    end
  end
`endif

  assign bus.senal_compuerta      = r_gate;
  assign bus.senal_alarma_pin     = r_alpin;
  assign bus.senal_alarma_bloqueo = r_blk;
  assign bus.senal_lleno          = r_lleno;
  assign bus.senal_timeout        = r_to;
  assign bus.cuenta_intentos      = r_cnt;
  assign bus.ocupacion            = r_occ;

endmodule

// File: tb/tb_acceso_parqueo_ctrl_param.sv
// Bench for acceso_parqueo_ctrl_param: directed plan steps then random
// traffic, every cycle compared against a flag-based reference model.
module tb_acceso_parqueo_ctrl_param;
  localparam int          CAP  = 2;
  localparam int          MAXI = 3;
  localparam int          TMO  = 8;
  localparam logic [15:0] PIN  = 16'h3257;
`ifdef ACCESO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  acceso_parqueo_ctrl_param_if #(
    .PIN_WIDTH(16), .CNT_W(2), .OCC_W(4)
  ) bus ();

  acceso_parqueo_ctrl_param #(
    .PIN_WIDTH(16),
    .PIN_CORRECTO(PIN),
    .MAX_INTENTOS(MAXI),
    .CAPACIDAD(CAP),
    .OCC_W(4),
    .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Reference model: situation flags instead of a state register.
  bit m_gate, m_pal, m_bal, m_wait, m_seen, m_to;
  bit m_pi, m_ps;
  int m_tries, m_occ, m_tmr;

  task automatic m_reset();
    m_gate = 0; m_pal = 0; m_bal = 0; m_wait = 0;
    m_seen = 0; m_to = 0; m_pi = 0; m_ps = 0;
    m_tries = 0; m_occ = 0; m_tmr = 0;
  endtask

  task automatic open_gate();
    m_gate = 1; m_seen = 0; m_tmr = 0; m_tries = 0;
    m_pal = 0; m_bal = 0; m_wait = 0;
  endtask

  task automatic m_step(bit ll, bit ing, bit sal,
                        bit kv, logic [15:0] k);
    bit fall, leave, ok, wrong, full;
    fall  = m_pi && !ing;
    leave = sal && !m_ps;
    ok    = kv && (k == PIN);
    wrong = kv && !ok;
    full  = (m_occ == CAP);
    m_to  = 0;
    if (m_bal) begin
      if (ok) open_gate();
    end else if (m_gate) begin
      if (fall) begin
        m_gate = 0;
        if (!leave && m_occ < CAP) m_occ++;
        leave = 0;
      end else if (TMO_EN && !m_seen) begin
        if (ing) m_seen = 1;
        else begin
          m_tmr++;
          if (m_tmr == TMO) begin
            m_gate = 0;
            m_to = 1;
          end
        end
      end
    end else if (m_pal) begin
      if (ing) m_bal = 1;
      else if (ok) open_gate();
    end else if (m_wait) begin
      if (ing) begin
        m_bal = 1; m_wait = 0;
      end else if (ok) open_gate();
      else if (wrong) begin
        m_tries++;
        if (m_tries == MAXI) begin
          m_wait = 0; m_pal = 1;
        end
      end else if (!ll) begin
        m_wait = 0; m_tries = 0;
      end
    end else begin
      if (ing) m_bal = 1;
      else if (ll && !full) m_wait = 1;
    end
    if (leave && m_occ > 0) m_occ--;
    m_pi = ing;
    m_ps = sal;
  endtask

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".gate"}, 32'(bus.senal_compuerta), 32'(m_gate));
    chk({tag, ".apin"}, 32'(bus.senal_alarma_pin), 32'(m_pal));
    chk({tag, ".ablk"}, 32'(bus.senal_alarma_bloqueo), 32'(m_bal));
    chk({tag, ".full"}, 32'(bus.senal_lleno), 32'(m_occ == CAP));
    chk({tag, ".tmo"}, 32'(bus.senal_timeout), 32'(m_to));
    chk({tag, ".cnt"}, 32'(bus.cuenta_intentos), 32'(m_tries));
    chk({tag, ".occ"}, 32'(bus.ocupacion), 32'(m_occ));
  endtask

  task automatic cyc(string tag);
    @(posedge clock);
    if (reset) m_reset();
    else m_step(bus.sensor_llegada_vehiculo,
                bus.sensor_ingreso_vehiculo,
                bus.sensor_salida_vehiculo,
                bus.clave_valida, bus.clave_ingresada);
    #1;
    check_all(tag);
  endtask

  task automatic pin(string tag, logic [15:0] v);
    bus.clave_valida = 1; bus.clave_ingresada = v;
    cyc(tag);
    bus.clave_valida = 0;
    cyc(tag);
  endtask

  task automatic pass_gate(string tag);
    bus.sensor_ingreso_vehiculo = 1;
    cyc(tag);
    bus.sensor_ingreso_vehiculo = 0;
    cyc(tag);
  endtask

  task automatic entry(string tag);
    bus.sensor_llegada_vehiculo = 1;
    cyc(tag);
    pin(tag, PIN);
    pass_gate(tag);
    bus.sensor_llegada_vehiculo = 0;
    cyc(tag);
  endtask

  task automatic depart(string tag);
    bus.sensor_salida_vehiculo = 1;
    cyc(tag);
    bus.sensor_salida_vehiculo = 0;
    cyc(tag);
  endtask

  initial begin
    bus.sensor_llegada_vehiculo = 0;
    bus.sensor_ingreso_vehiculo = 0;
    bus.sensor_salida_vehiculo  = 0;
    bus.clave_ingresada         = '0;
    bus.clave_valida            = 0;
    m_reset();
    reset = 1;
    cyc("rst");
    cyc("rst");
    reset = 0;
    cyc("idle");

    // normal entry
    bus.sensor_llegada_vehiculo = 1;
    cyc("n.arr");
    bus.clave_valida = 1; bus.clave_ingresada = PIN;
    cyc("n.pin");
    chk("n.gate_open", 32'(bus.senal_compuerta), 32'd1);
    bus.clave_valida = 0;
    cyc("n.wait");
    pass_gate("n.pass");
    chk("n.occ1", 32'(bus.ocupacion), 32'd1);
    bus.sensor_llegada_vehiculo = 0;
    cyc("n.done");
    depart("n.dep");

    // two wrong then correct
    bus.sensor_llegada_vehiculo = 1;
    cyc("w2.arr");
    pin("w2.p1", 16'h7523);
    pin("w2.p2", 16'h4368);
    chk("w2.cnt2", 32'(bus.cuenta_intentos), 32'd2);
    pin("w2.p3", PIN);
    pass_gate("w2.pass");
    bus.sensor_llegada_vehiculo = 0;
    cyc("w2.done");
    depart("w2.dep");

    // three wrong -> pin alarm
    bus.sensor_llegada_vehiculo = 1;
    cyc("w3.arr");
    pin("w3.p1", 16'h7523);
    pin("w3.p2", 16'h4368);
    pin("w3.p3", 16'h2656);
    chk("w3.alarm", 32'(bus.senal_alarma_pin), 32'd1);
    pin("w3.p4", 16'h1111);
    chk("w3.sat", 32'(bus.cuenta_intentos), 32'd3);
    pin("w3.ok", PIN);
    pass_gate("w3.pass");
    bus.sensor_llegada_vehiculo = 0;
    cyc("w3.done");
    depart("w3.dep");

    // intrusion: arrival and passage rise together
    bus.sensor_llegada_vehiculo = 1;
    bus.sensor_ingreso_vehiculo = 1;
    cyc("b.trig");
    chk("b.alarm", 32'(bus.senal_alarma_bloqueo), 32'd1);
    pin("b.wrong", 16'h5479);
    pin("b.ok", PIN);
    bus.sensor_ingreso_vehiculo = 0;
    cyc("b.fall");
    bus.sensor_llegada_vehiculo = 0;
    cyc("b.done");
    depart("b.dep");

    // capacity limit
    entry("c.e1");
    entry("c.e2");
    chk("c.full", 32'(bus.senal_lleno), 32'd1);
    bus.sensor_llegada_vehiculo = 1;
    cyc("c.arr");
    pin("c.pin", PIN);
    chk("c.nogate", 32'(bus.senal_compuerta), 32'd0);
    bus.sensor_llegada_vehiculo = 0;
    cyc("c.left");
    depart("c.dep");
    chk("c.occ1", 32'(bus.ocupacion), 32'd1);
    bus.sensor_llegada_vehiculo = 1;
    cyc("c.arr2");
    pin("c.pin2", PIN);
    bus.sensor_ingreso_vehiculo = 1;
    cyc("c.in");
    bus.sensor_ingreso_vehiculo = 0;
    bus.sensor_salida_vehiculo  = 1;
    cyc("c.both");
    chk("c.same", 32'(bus.ocupacion), 32'd1);
    bus.sensor_salida_vehiculo  = 0;
    bus.sensor_llegada_vehiculo = 0;
    cyc("c.done");
    depart("c.dep2");

    // gate opened, nobody drives through
    bus.sensor_llegada_vehiculo = 1;
    cyc("t.arr");
    bus.clave_valida = 1; bus.clave_ingresada = PIN;
    cyc("t.pin");
    bus.clave_valida = 0;
    bus.sensor_llegada_vehiculo = 0;
    for (int i = 0; i < 100; i++) cyc("t.run");
    chk("t.gate100", 32'(bus.senal_compuerta), 32'(!TMO_EN));
    // reset aborts whatever is going on
    reset = 1;
    cyc("t.rst");
    reset = 0;
    cyc("t.idle");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 6) == 0)
        bus.sensor_llegada_vehiculo = !bus.sensor_llegada_vehiculo;
      if ($urandom_range(0, 9) == 0)
        bus.sensor_ingreso_vehiculo = !bus.sensor_ingreso_vehiculo;
      if ($urandom_range(0, 5) == 0)
        bus.sensor_salida_vehiculo = !bus.sensor_salida_vehiculo;
      bus.clave_valida = ($urandom_range(0, 3) == 0);
      bus.clave_ingresada = ($urandom_range(0, 1) == 0) ?
        PIN : 16'($urandom);
      reset = ($urandom_range(0, 400) == 0);
      cyc("rnd");
    end
    reset = 0;
    bus.clave_valida = 0;
    cyc("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
